// File: rtl/decoder_pkg.sv
// Shared decoder types: opcode constants, ALU funct3 encoding and the
// decoded-operation bundle carried from decode to the ALU side.
package decoder_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        SLL  = 3'b001,
        SLT  = 3'b010,
        SLTU = 3'b011,
        XOR  = 3'b100,
        SR   = 3'b101,
        OR   = 3'b110,
        AND  = 3'b111
    } funct3_e;

    typedef struct packed {
        funct3_e     funct3;
        logic        funct7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd_addr;
        logic        illegal;
    } dec_op_t;

endpackage

// File: rtl/decoder_if.sv
// Decoder bus: instruction input handshake, register write-back and the
// decoded-operation output handshake. master drives instructions/write-back,
// slave is the decoder.
interface decoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_addr;
    logic        illegal;

    modport master (
        output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, funct3, funct7, rs1, rs2,
        input  rd_addr, illegal
    );

    modport slave (
        input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, funct3, funct7, rs1, rs2,
        output rd_addr, illegal
    );

endinterface

// File: rtl/decoder_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port, synchronous active-low reset; x0 always reads 0.
// Ports: clk, rst_n, raddr1/rdata1, raddr2/rdata2, we/waddr/wdata.
// DECODER_BYPASS_EN: a read matching a same-cycle write returns wdata.
module decoder_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef DECODER_BYPASS_EN
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 :
                    (we && waddr == raddr1) ? wdata : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 :
                    (we && waddr == raddr2) ? wdata : regs[raddr2];
`else
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
`endif

endmodule

// File: rtl/decoder.sv
// RV32I OP/OP-IMM decoder with register file and a single output register.
// Ports: clk, rst_n (sync, active-low), bus (decoder_if.slave).
// Optional DECODER_BYPASS_EN: write-back bypass into same-cycle reads.
module decoder
    import decoder_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    decoder_if.slave bus
);

    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        out_valid;
    dec_op_t     op_q;
    dec_op_t     op_d;
    logic        accept;
    logic [6:0]  opcode;
    funct3_e     f3;
    logic        is_shift;

    decoder_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (bus.instr[19:15]),
        .raddr2 (bus.instr[24:20]),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (bus.wb_en),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data)
    );

    assign bus.in_ready = !out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign opcode   = bus.instr[6:0];
    assign f3       = funct3_e'(bus.instr[14:12]);
    // Immediate shifts take only the 5-bit shamt as operand B.
    assign is_shift = (f3 == SLL) || (f3 == SR);

    always_comb begin
        op_d         = '0;
        op_d.rd_addr = bus.instr[11:7];
        unique case (1'b1)
            (opcode == OP): begin
                op_d.funct3 = f3;
                op_d.funct7 = bus.instr[30];
                op_d.rs1    = rdata1;
                op_d.rs2    = rdata2;
            end
            (opcode == OP_IMM): begin
                op_d.funct3 = f3;
                op_d.funct7 = (f3 == SR) ? bus.instr[30] : 1'b0;
                op_d.rs1    = rdata1;
                op_d.rs2    = is_shift ?
                              {27'd0, bus.instr[24:20]} :
                              {{20{bus.instr[31]}}, bus.instr[31:20]};
            end
            default: begin
                op_d.illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            op_q      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            op_q      <= op_d;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.funct3    = op_q.funct3;
    assign bus.funct7    = op_q.funct7;
    assign bus.rs1       = op_q.rs1;
    assign bus.rs2       = op_q.rs2;
    assign bus.rd_addr   = op_q.rd_addr;
    assign bus.illegal   = op_q.illegal;

endmodule
